// File: rtl/forward_ctrl_unit.sv
// EX-stage operand forwarding selects and load-use stall detection for a
// 5-stage pipeline, tracking its own ID/EX, EX/MEM and MEM/WB destination records.
module forward_ctrl_unit #(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              id_valid_i,
  input  logic [REG_AW-1:0] id_rs1_i,
  input  logic [REG_AW-1:0] id_rs2_i,
  input  logic              id_use_rs1_i,
  input  logic              id_use_rs2_i,
  input  logic [REG_AW-1:0] id_rd_i,
  input  logic              id_regwrite_i,
  input  logic              id_memread_i,
  input  logic              flush_i,
  output logic [1:0]        forward_a_o,
  output logic [1:0]        forward_b_o,
  output logic              stall_o,
  output logic [CNT_W-1:0]  stall_cnt_o
);

  localparam logic [1:0]        SEL_RF   = 2'b00;
  localparam logic [1:0]        SEL_WB   = 2'b01;
  localparam logic [1:0]        SEL_MEM  = 2'b10;
  localparam logic [REG_AW-1:0] REG_ZERO = {REG_AW{1'b0}};
  localparam logic [CNT_W-1:0]  CNT_MAX  = {CNT_W{1'b1}};

  logic              ex_valid_r, ex_use1_r, ex_use2_r, ex_regwrite_r, ex_memread_r;
  logic [REG_AW-1:0] ex_rs1_r, ex_rs2_r, ex_rd_r;
  logic              mem_valid_r, mem_regwrite_r;
  logic [REG_AW-1:0] mem_rd_r;
  logic              wb_valid_r, wb_regwrite_r;
  logic [REG_AW-1:0] wb_rd_r;
  logic [CNT_W-1:0]  stall_cnt_r;
  logic              stall_s;
  logic              ex_load_s;

  // The younger EX/MEM producer is checked first so it wins over MEM/WB.
  function automatic logic [1:0] fwd_sel(
    input logic              ex_valid,
    input logic              ex_use,
    input logic [REG_AW-1:0] ex_rs,
    input logic              mem_valid,
    input logic              mem_regwrite,
    input logic [REG_AW-1:0] mem_rd,
    input logic              wb_valid,
    input logic              wb_regwrite,
    input logic [REG_AW-1:0] wb_rd
  );
    logic [1:0] sel;
    sel = SEL_RF;
    if (ex_valid && ex_use && mem_valid && mem_regwrite &&
        (mem_rd != REG_ZERO) && (mem_rd == ex_rs)) begin
      sel = SEL_MEM;
    end else if (ex_valid && ex_use && wb_valid && wb_regwrite &&
                 (wb_rd != REG_ZERO) && (wb_rd == ex_rs)) begin
      sel = SEL_WB;
    end else begin
      sel = SEL_RF;
    end
    return sel;
  endfunction

  // Load-use hazard: a load in EX feeding the instruction in ID; flush overrides.
  always_comb begin
    stall_s = 1'b0;
    if (!flush_i && id_valid_i && ex_valid_r && ex_memread_r &&
        ex_regwrite_r && (ex_rd_r != REG_ZERO)) begin
      stall_s = (id_use_rs1_i && (id_rs1_i == ex_rd_r)) ||
                (id_use_rs2_i && (id_rs2_i == ex_rd_r));
    end else begin
      stall_s = 1'b0;
    end
  end

  assign ex_load_s   = id_valid_i && !flush_i && !stall_s;
  assign forward_a_o = fwd_sel(ex_valid_r, ex_use1_r, ex_rs1_r, mem_valid_r, mem_regwrite_r,
                               mem_rd_r, wb_valid_r, wb_regwrite_r, wb_rd_r);
  assign forward_b_o = fwd_sel(ex_valid_r, ex_use2_r, ex_rs2_r, mem_valid_r, mem_regwrite_r,
                               mem_rd_r, wb_valid_r, wb_regwrite_r, wb_rd_r);
  assign stall_o     = stall_s;
  assign stall_cnt_o = stall_cnt_r;

  // Shadow pipeline records; a bubble enters EX on flush, stall or empty ID.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      ex_valid_r     <= 1'b0;
      ex_use1_r      <= 1'b0;
      ex_use2_r      <= 1'b0;
      ex_regwrite_r  <= 1'b0;
      ex_memread_r   <= 1'b0;
      ex_rs1_r       <= REG_ZERO;
      ex_rs2_r       <= REG_ZERO;
      ex_rd_r        <= REG_ZERO;
      mem_valid_r    <= 1'b0;
      mem_regwrite_r <= 1'b0;
      mem_rd_r       <= REG_ZERO;
      wb_valid_r     <= 1'b0;
      wb_regwrite_r  <= 1'b0;
      wb_rd_r        <= REG_ZERO;
    end else begin
      wb_valid_r     <= mem_valid_r;
      wb_regwrite_r  <= mem_regwrite_r;
      wb_rd_r        <= mem_rd_r;
      mem_valid_r    <= ex_valid_r;
      mem_regwrite_r <= ex_regwrite_r;
      mem_rd_r       <= ex_rd_r;
      if (ex_load_s) begin
        ex_valid_r    <= 1'b1;
        ex_use1_r     <= id_use_rs1_i;
        ex_use2_r     <= id_use_rs2_i;
        ex_regwrite_r <= id_regwrite_i;
        ex_memread_r  <= id_memread_i;
        ex_rs1_r      <= id_rs1_i;
        ex_rs2_r      <= id_rs2_i;
        ex_rd_r       <= id_rd_i;
      end else begin
        ex_valid_r    <= 1'b0;
      end
    end
  end

  // Saturating stall counter for performance monitoring.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      stall_cnt_r <= {CNT_W{1'b0}};
    end else if (stall_s && (stall_cnt_r != CNT_MAX)) begin
      stall_cnt_r <= stall_cnt_r + CNT_W'(1);
    end else begin
      stall_cnt_r <= stall_cnt_r;
    end
  end

endmodule

// File: doc/forward_ctrl_unit.md
Name: forward_ctrl_unit

Overview:
- Generates the 2-bit operand-select codes consumed by the EX-stage operand multiplexers of the 5-stage pipelined CPU.
- Produces the load-use stall request for the IF/ID stages.
- Keeps its own shadow copy of the destination-register bookkeeping for the ID/EX, EX/MEM and MEM/WB stages, so the datapath needs to supply only decode-stage fields plus flush.
- Also keeps a saturating count of load-use stalls for performance monitoring.

Parameters:
- REG_AW, 5, register-address width (32 architectural registers; x0 hardwired zero).
- CNT_W, 16, width of the stall performance counter.

Ports:
- clk_i  input  1  clock; all state updates on the rising edge.
- rst_i  input  1  synchronous active-low reset.
- id_valid_i  input  1  the ID stage holds a real instruction.
- id_rs1_i  input  REG_AW  source register 1 of the ID instruction.
- id_rs2_i  input  REG_AW  source register 2 of the ID instruction.
- id_use_rs1_i  input  1  the ID instruction reads rs1.
- id_use_rs2_i  input  1  the ID instruction reads rs2.
- id_rd_i  input  REG_AW  destination register of the ID instruction.
- id_regwrite_i  input  1  the ID instruction writes rd.
- id_memread_i  input  1  the ID instruction is a load.
- flush_i  input  1  kill the ID instruction (taken branch); a bubble enters EX.
- forward_a_o  output  2  operand A select for the EX instruction.
- forward_b_o  output  2  operand B select for the EX instruction.
- stall_o  output  1  hold PC and IF/ID; a bubble enters EX.
- stall_cnt_o  output  CNT_W  saturating count of cycles with stall_o=1.

Behaviour:
- Select encoding:
  - 2'b00 = register-file value.
  - 2'b01 = MEM/WB write-back value.
  - 2'b10 = EX/MEM ALU result.
  - 2'b11 is never driven.
- Internal state, three stage records:
  - EX (ID/EX): valid, rs1, rs2, use1, use2, rd, regwrite, memread.
  - MEM (EX/MEM): valid, rd, regwrite.
  - WB (MEM/WB): valid, rd, regwrite.
- Reset (rst_i=0 sampled at a rising edge):
  - All valid bits and stall_cnt_o clear to 0.
  - Consequently forward_a_o=forward_b_o=2'b00 and stall_o=0 from the first cycle after reset.
  - Reset mid-operation discards all in-flight records.
- Each rising edge with rst_i=1:
  - WB <= MEM and MEM <= EX (the load flag is dropped).
  - EX <= bubble (valid=0) if flush_i=1, stall_o=1 or id_valid_i=0.
  - Otherwise EX <= ID fields with valid=1.
- Forwarding (combinational from registered state; zero-cycle latency to the EX muxes), shown for A; B is identical with rs2/use2:
  - forward_a_o=2'b10 if EX.valid & EX.use1 & MEM.valid & MEM.regwrite & MEM.rd!=0 & MEM.rd==EX.rs1.
  - Else forward_a_o=2'b01 if the same condition holds with WB in place of MEM.
  - Else forward_a_o=2'b00.
  - When both MEM and WB match, EX/MEM wins because it is the younger producer.
  - rd=0 never forwards.
- Load-use stall (combinational):
  - stall_o=1 iff flush_i=0 & id_valid_i=1 & EX.valid & EX.memread & EX.regwrite & EX.rd!=0 & ((id_use_rs1_i & id_rs1_i==EX.rd) | (id_use_rs2_i & id_rs2_i==EX.rd)).
  - Stall lasts exactly one cycle per load: the load moves to MEM and a bubble enters EX. On the following cycle the consumer forwards with 2'b01 after the load reaches WB.
  - flush_i and a hazard in the same cycle: flush wins, stall_o=0, bubble inserted.
- Counter:
  - stall_cnt_o increments by 1 on each edge where stall_o=1.
  - It saturates at 2^CNT_W-1 and never wraps.

Test Plan:
- Reset: hold rst_i=0 for 2 cycles, then release → forward_a_o=forward_b_o=00, stall_o=0, stall_cnt_o=0.
- Back-to-back ALU ops:
  - Issue add x5 (regwrite, rd=5), then sub x6,x5,x5 (rs1=rs2=5).
  - Cycle the sub is in EX → forward_a_o=forward_b_o=10.
  - Insert one nop between them instead → both =01.
- Priority and x0:
  - Issue add x7, add x7, then or using x7 → forward_a_o=10, not 01.
  - Repeat with rd=0 and rs1=0 → 00.
- Load-use:
  - Issue lw x8 (memread, rd=8), then add using rs2=8 → stall_o=1 for exactly one cycle and stall_cnt_o increments by 1.
  - Next cycle the add is in EX with forward_b_o=01 and forward_a_o=00.
- Flush:
  - Assert flush_i in the same cycle stall_o would assert → stall_o=0 and next cycle EX is a bubble (forward outputs 00).
  - A later x8 consumer still forwards 01 from WB.
- Saturation: set CNT_W=2 and create 5 load-use stalls → stall_cnt_o=3 and holds.
